// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// word geometry and the address legality check.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned WORD_BYTES = 8;
   localparam int unsigned OFS_W      = $clog2(WORD_BYTES);

   // True when the byte address is not word aligned or lies past the last word.
   function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth);
      return (addr[OFS_W-1:0] != '0) || ((addr >> OFS_W) >= 64'(depth));
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM of 64-bit words with a registered read port.
// Contents and the read register are not reset.
module dmem_array #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned IDX_W = 7
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata
);

   logic [63:0] mem [DEPTH];
   logic [63:0] rdata_q;

   // Read-before-write: a store edge returns the old word, which the responder discards.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata_q <= mem[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, stalls WAIT_CYCLES, performs the
// access, then holds the response until the initiator takes it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output state_e      dbg_state
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (WAIT_CYCLES >= (2 ** CNT_W)) begin : g_cnt_check
      $error("dmem_responder: WAIT_CYCLES does not fit in CNT_W bits");
   end

   // Handshake: a transfer happens on a posedge where valid and ready are both
   // high; once raised, rsp_valid and its payload hold until such an edge.
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [63:0]        addr_q, addr_d;
   logic [63:0]        wdata_q, wdata_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rd_sel_q, rd_sel_d;
   logic               mem_we;
   logic               acc_err;
   logic [63:0]        arr_rdata;

   assign acc_err = addr_err(addr_q, DEPTH);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rd_sel_d    = rd_sel_q;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               mem_we      = wr_q && !acc_err;
               rd_sel_d    = !wr_q && !acc_err;
               rsp_err_d   = acc_err;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rd_sel_d    = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_sel_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_sel_q    <= rd_sel_d;
      end
   end

   // The RAM read register is the load-data flop; rd_sel_q forces zero for
   // stores, errors, idle and reset.
   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (CLK),
      .we    (mem_we),
      .idx   (addr_q[OFS_W +: IDX_W]),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rd_sel_q ? arr_rdata : '0;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, hand-written stall/reset/zero-wait
// sequences and random traffic against a word-map reference model.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int unsigned DEPTH       = 128;
   localparam int unsigned WAIT_CYCLES = 2;
   localparam int          TMO         = 64;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        resetl;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_rdata;
   state_e      dbg_state;

   logic        d0_resetl, d0_req_ready, d0_req_write, d0_rsp_valid, d0_rsp_err;
   logic [63:0] d0_req_addr, d0_req_wdata, d0_rsp_rdata;
   state_e      d0_dbg_state;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .CNT_W(8)) u_dut (
      .CLK       (CLK),
      .resetl    (resetl),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .dbg_state (dbg_state)
   );

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .CNT_W(8)) u_dut0 (
      .CLK       (CLK),
      .resetl    (d0_resetl),
      .req_valid (1'b1),
      .req_ready (d0_req_ready),
      .req_write (d0_req_write),
      .req_addr  (d0_req_addr),
      .req_wdata (d0_req_wdata),
      .rsp_valid (d0_rsp_valid),
      .rsp_ready (1'b1),
      .rsp_rdata (d0_rsp_rdata),
      .rsp_err   (d0_rsp_err),
      .dbg_state (d0_dbg_state)
   );

   // ---------------- scoreboard / model ----------------
   int vec_cnt  = 0;
   int miss_cnt = 0;
   logic [63:0]     exp_q[$];
   logic            exp_err_q[$];
   logic [63:0]     ref_mem [longint unsigned];
   longint unsigned written_q[$];

   typedef struct {
      logic        w;
      logic [63:0] a;
      logic [63:0] d;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s: no event within %0d cycles", name, TMO);
   endtask

   // Reference: memory is a map of word index -> data; errors never touch it.
   function automatic void model_apply(input logic w, input logic [63:0] a, input logic [63:0] d,
                                       output logic [63:0] rd, output logic e);
      longint unsigned widx;
      e    = (a % 64'd8 != 64'd0) || (a / 64'd8 >= 64'(DEPTH));
      rd   = '0;
      widx = longint'(a / 64'd8);
      if (!e) begin
         if (w) begin
            if (!ref_mem.exists(widx)) written_q.push_back(widx);
            ref_mem[widx] = d;
         end else begin
            rd = ref_mem.exists(widx) ? ref_mem[widx] : 'x;
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_req(input logic w, input logic [63:0] a, input logic [63:0] d, output bit ok);
      int n = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < TMO) begin
         @(negedge CLK);
         n++;
      end
      ok = req_ready;
      if (!ok) begin
         req_valid = 1'b0;
         tmo("accept");
         return;
      end
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
   endtask

   task automatic wait_rsp(output int lat, output bit ok);
      lat = 0;
      do begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
      end while (!rsp_valid && lat < TMO);
      ok = rsp_valid;
      if (!ok) tmo("rsp_valid");
   endtask

   task automatic take_rsp(input string name, input logic [63:0] exp_rd, input logic exp_err, input int hold);
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         chk1({name, "_hold_valid"}, rsp_valid, 1'b1);
         chk({name, "_hold_rdata"}, rsp_rdata, exp_rd);
         chk1({name, "_hold_err"}, rsp_err, exp_err);
         chk1({name, "_hold_req_ready"}, req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      rsp_ready = 1'b0;
      chk1({name, "_done_valid"}, rsp_valid, 1'b0);
      chk({name, "_done_rdata"}, rsp_rdata, 64'd0);
      chk1({name, "_done_err"}, rsp_err, 1'b0);
      chk1({name, "_done_req_ready"}, req_ready, 1'b1);
   endtask

   task automatic do_txn(input string name, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] exp_rd, input logic exp_err, input int hold);
      bit ok;
      int lat;
      send_req(w, a, d, ok);
      if (!ok) return;
      wait_rsp(lat, ok);
      if (!ok) return;
      chk({name, "_lat"}, 64'(lat), 64'(WAIT_CYCLES + 1));
      chk({name, "_rdata"}, rsp_rdata, exp_rd);
      chk1({name, "_err"}, rsp_err, exp_err);
      take_rsp(name, exp_rd, exp_err, hold);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [63:0] m_rd;
      logic        m_err;
      bit          ok;
      int          lat;

      resetl       = 1'b0;
      d0_resetl    = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      rsp_ready    = 1'b0;
      d0_req_write = 1'b1;
      d0_req_addr  = '0;
      d0_req_wdata = '0;

      #2;
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_state_idle", dbg_state == IDLE, 1'b1);
      repeat (2) @(negedge CLK);
      resetl = 1'b1;

      // Vector table: basic store/load, misalignment, range edges.
      tbl.push_back('{1'b1, 64'h8,   64'hDEADBEEF_CAFEF00D, 64'd0,                  1'b0});
      tbl.push_back('{1'b0, 64'h8,   64'd0,                 64'hDEADBEEF_CAFEF00D,  1'b0});
      tbl.push_back('{1'b0, 64'hC,   64'd0,                 64'd0,                  1'b1});
      tbl.push_back('{1'b1, 64'hC,   64'h1,                 64'd0,                  1'b1});
      tbl.push_back('{1'b0, 64'h8,   64'd0,                 64'hDEADBEEF_CAFEF00D,  1'b0});
      tbl.push_back('{1'b1, 64'h400, 64'h55,                64'd0,                  1'b1});
      tbl.push_back('{1'b1, 64'h3F8, 64'h77,                64'd0,                  1'b0});
      tbl.push_back('{1'b0, 64'h3F8, 64'd0,                 64'h77,                 1'b0});
      tbl.push_back('{1'b0, 64'h400, 64'd0,                 64'd0,                  1'b1});
      tbl.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0,                  1'b1});
      tbl.push_back('{1'b1, 64'h0,   64'h0123_4567_89AB_CDEF, 64'd0,                1'b0});
      tbl.push_back('{1'b0, 64'h0,   64'd0,                 64'h0123_4567_89AB_CDEF, 1'b0});
      for (int i = 0; i < tbl.size(); i++) begin
         model_apply(tbl[i].w, tbl[i].a, tbl[i].d, m_rd, m_err);
         do_txn($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, tbl[i].exp_err, i % 3);
      end

      // Backpressure: response held 5 cycles while a store is offered and ignored.
      model_apply(1'b1, 64'h20, 64'hAAAA, m_rd, m_err);
      do_txn("bp_st20", 1'b1, 64'h20, 64'hAAAA, 64'd0, 1'b0, 0);
      model_apply(1'b1, 64'h30, 64'h1234, m_rd, m_err);
      do_txn("bp_st30", 1'b1, 64'h30, 64'h1234, 64'd0, 1'b0, 0);
      send_req(1'b0, 64'h20, 64'd0, ok);
      if (ok) begin
         wait_rsp(lat, ok);
         chk("bp_lat", 64'(lat), 64'(WAIT_CYCLES + 1));
         for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 64'h30;
            req_wdata = 64'hBAD;
            chk1("bp_valid", rsp_valid, 1'b1);
            chk("bp_rdata", rsp_rdata, 64'hAAAA);
            chk1("bp_err", rsp_err, 1'b0);
            chk1("bp_req_ready", req_ready, 1'b0);
            @(posedge CLK);
            @(negedge CLK);
         end
         req_valid = 1'b0;
         take_rsp("bp_ld20", 64'hAAAA, 1'b0, 0);
      end
      do_txn("bp_ld30", 1'b0, 64'h30, 64'd0, 64'h1234, 1'b0, 0);

      // Reset during WAIT drops the in-flight store.
      model_apply(1'b1, 64'h10, 64'h1111, m_rd, m_err);
      do_txn("rw_st1111", 1'b1, 64'h10, 64'h1111, 64'd0, 1'b0, 0);
      send_req(1'b1, 64'h10, 64'h2222, ok);
      chk1("rw_in_wait", dbg_state == WAIT, 1'b1);
      resetl = 1'b0;
      #1;
      chk1("rw_rst_valid", rsp_valid, 1'b0);
      chk("rw_rst_rdata", rsp_rdata, 64'd0);
      chk1("rw_rst_err", rsp_err, 1'b0);
      chk1("rw_rst_state", dbg_state == IDLE, 1'b1);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      resetl = 1'b1;
      chk1("rw_post_req_ready", req_ready, 1'b1);
      chk1("rw_post_valid", rsp_valid, 1'b0);
      do_txn("rw_ld10", 1'b0, 64'h10, 64'd0, 64'h1111, 1'b0, 1);

      // Random traffic scored against the word-map model.
      for (int i = 0; i < 40; i++) begin
         logic        w;
         logic [63:0] a, d;
         int          sel;
         sel = $urandom_range(0, 9);
         w   = 1'($urandom_range(0, 1));
         d   = {$urandom, $urandom};
         if (sel < 6) begin
            if (w) a = 64'($urandom_range(0, DEPTH - 1)) << 3;
            else   a = 64'(written_q[$urandom_range(0, written_q.size() - 1)]) << 3;
         end else if (sel < 8) begin
            a = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(1, 7));
         end else if (sel == 8) begin
            a = 64'($urandom_range(DEPTH, 4 * DEPTH)) << 3;
         end else begin
            a = {$urandom | 32'h1, $urandom & 32'hFFFF_FFF8};
         end
         model_apply(w, a, d, m_rd, m_err);
         exp_q.push_back(m_rd);
         exp_err_q.push_back(m_err);
         do_txn($sformatf("rnd%0d", i), w, a, d, exp_q.pop_front(), exp_err_q.pop_front(),
                $urandom_range(0, 2));
      end

      // Zero-wait instance, both valid and ready tied high: accept every 3 cycles.
      d0_req_addr  = 64'h0;
      d0_req_wdata = 64'hA0;
      @(negedge CLK);
      d0_resetl = 1'b1;
      for (int n = 0; n < 9; n++) begin
         chk1($sformatf("z_req_ready%0d", n), d0_req_ready, (n % 3) == 0);
         chk1($sformatf("z_rsp_valid%0d", n), d0_rsp_valid, (n % 3) == 2);
         chk($sformatf("z_rdata%0d", n), d0_rsp_rdata, 64'd0);
         chk1($sformatf("z_err%0d", n), d0_rsp_err, 1'b0);
         @(posedge CLK);
         @(negedge CLK);
         if ((n % 3) == 0) begin
            d0_req_addr  = d0_req_addr + 64'h8;
            d0_req_wdata = d0_req_wdata + 64'h1;
         end
      end
      d0_resetl = 1'b0;

      // ---------------- final report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
